// File: rtl/hamming_tx_serializer_if.sv
// Word-input handshake for the Hamming transmit serializer.
// The master offers s_data/s_valid; the slave answers with s_ready.
interface hamming_tx_serializer_if #(
   parameter int K = 4
) ();
   logic [K-1:0] s_data;
   logic         s_valid;
   logic         s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/hamming_tx_serializer.sv
// Scrambles a K-bit word, appends Hamming parity and shifts the codeword out
// LSB first inside a start(0)/stop(1) frame, one bit per baud_tick.
module hamming_tx_serializer #(
   parameter int K   = 4,
   parameter int N   = 7,
   parameter int C   = 3,
   parameter int ENC = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           baud_tick_i,
   hamming_tx_serializer_if.slave         s_if,
   output logic                           tx_o,
   output logic                           busy_o,
   output logic                           frame_done_o
);
   localparam int CNT_W = $clog2(N);
   // One 8-bit parity mask lane per parity bit, lane j drives p[j].
   localparam logic [31:0] MASKS = (K == 8) ? 32'h0F71_B7DB : 32'h000E_0B0D;

   generate
      if (!((K == 4 && N == 7 && C == 3) || (K == 8 && N == 12 && C == 4))) begin : g_bad_cfg
         $error("hamming_tx_serializer: unsupported K/N/C combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_q, tx_d;

   logic [K-1:0]     x;
   logic [C-1:0]     par;
   logic [N-1:0]     cw;
   logic             s_ready, busy, frame_done;

   assign x = (ENC != 0) ? ~s_if.s_data : s_if.s_data;

   genvar gi;
   generate
      for (gi = 0; gi < C; gi++) begin : g_par
         assign par[gi] = ^(x & MASKS[gi*8 +: K]);
      end
   endgenerate

   assign cw = {x, par};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
      end
   end

   // The shift register always presents the next codeword bit at shreg_q[0].
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (s_if.s_valid && s_ready) begin
               state_d = START;
               shreg_d = cw;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (baud_tick_i) begin
               state_d = DATA;
               cnt_d   = '0;
               tx_d    = shreg_q[0];
               shreg_d = {1'b0, shreg_q[N-1:1]};
            end
         end
         DATA: begin
            if (baud_tick_i) begin
               if (cnt_q == CNT_W'(N - 1)) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  tx_d    = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[N-1:1]};
               end
            end
         end
         STOP: begin
            if (baud_tick_i) begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_ready    = (state_q == IDLE);
      busy       = (state_q != IDLE);
      frame_done = (state_q == STOP) && baud_tick_i;
   end

   assign s_if.s_ready = s_ready;
   assign busy_o       = busy;
   assign frame_done_o = frame_done;
   assign tx_o         = tx_q;
endmodule
